// File: rtl/deco_anillo_rx.sv
`default_nettype none
// ============================================================================
// Module   : deco_anillo_rx
// Purpose  : Monitors a 4-digit multiplexed seven-segment scan bus (active-low
//            anodes and segments). It rebuilds the displayed digits as segment
//            patterns and hex values, checks the ring scan order (3,2,1,0) and
//            flags malformed anode patterns.
// Revision : 1.0 - initial release
// ============================================================================
module deco_anillo_rx #(
  parameter int STABLE_CYCLES = 1
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [3:0]  i_Anodos,
  input  logic [6:0]  i_Segmentos,
  input  logic        i_ClrErr,
  output logic [27:0] o_Segs,
  output logic [15:0] o_Valor,
  output logic [3:0]  o_DigValid,
  output logic        o_Frame,
  output logic        o_ErrPatron,
  output logic        o_ErrOrden
);

  // Capture threshold, clipped to the counter width (legal range 1..15)
  localparam logic [3:0] C_STABLE_THR = 4'(STABLE_CYCLES);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Registered scan bus (the spec's r_An / r_Sg)
  logic [3:0]  an_q, an_d;
  logic [6:0]  sg_q, sg_d;
  // Dwell tracking
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  // Reconstructed display
  logic [27:0] segs_q, segs_d;
  logic [15:0] valor_q, valor_d;
  logic [3:0]  digvalid_q, digvalid_d;
  // Order checking
  state_t      state_q, state_d;
  logic [1:0]  exp_q, exp_d;
  logic        frame_q, frame_d;
  logic        errpat_q, errpat_d;
  logic        errord_q, errord_d;

  // Pattern classification and capture decision
  logic        w_change;
  logic        w_legal;
  logic        w_illegal;
  logic [1:0]  w_dig;
  logic        w_capture;
  logic [6:0]  w_seg_ah;
  logic [4:0]  w_glyph;

  // Seven-segment (gfedcba, active-high) to hex; bit 4 flags a legal glyph
  function automatic logic [4:0] decode_glyph(input logic [6:0] s);
    case (s)
      7'h3F:   return {1'b1, 4'h0};
      7'h06:   return {1'b1, 4'h1};
      7'h5B:   return {1'b1, 4'h2};
      7'h4F:   return {1'b1, 4'h3};
      7'h66:   return {1'b1, 4'h4};
      7'h6D:   return {1'b1, 4'h5};
      7'h7D:   return {1'b1, 4'h6};
      7'h07:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h6F:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h7C:   return {1'b1, 4'hB};
      7'h39:   return {1'b1, 4'hC};
      7'h5E:   return {1'b1, 4'hD};
      7'h79:   return {1'b1, 4'hE};
      7'h71:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  // Classify the registered anodes and decide whether this cycle captures
  always_comb begin
    w_legal   = 1'b0;
    w_illegal = 1'b0;
    w_dig     = 2'd0;
    case (an_q)
      4'b0111: begin w_legal = 1'b1; w_dig = 2'd3; end
      4'b1011: begin w_legal = 1'b1; w_dig = 2'd2; end
      4'b1101: begin w_legal = 1'b1; w_dig = 2'd1; end
      4'b1110: begin w_legal = 1'b1; w_dig = 2'd0; end
      4'b1111: ;
      default: w_illegal = 1'b1;
    endcase
    // The change is detected against the incoming sample so that the counter
    // is already 1 on the edge that registers a new pattern.
    w_change  = ({i_Anodos, i_Segmentos} != {an_q, sg_q});
    w_capture = w_legal && armed_q && (cnt_q >= C_STABLE_THR);
    w_seg_ah  = ~sg_q;
    w_glyph   = decode_glyph(w_seg_ah);
  end

  // Next-state for input stage, dwell counter, display slots, order FSM, flags
  always_comb begin
    an_d       = i_Anodos;
    sg_d       = i_Segmentos;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    segs_d     = segs_q;
    valor_d    = valor_q;
    digvalid_d = digvalid_q;
    state_d    = state_q;
    exp_d      = exp_q;
    frame_d    = 1'b0;
    errpat_d   = i_ClrErr ? 1'b0 : errpat_q;
    errord_d   = i_ClrErr ? 1'b0 : errord_q;

    if (w_change) begin
      cnt_d = 4'd1;
    end else if (cnt_q != 4'd15) begin
      cnt_d = cnt_q + 4'd1;
    end

    // A change re-arms even when a capture fires on the same edge
    if (w_change) begin
      armed_d = 1'b1;
    end else if (w_capture) begin
      armed_d = 1'b0;
    end

    if (w_illegal) begin
      errpat_d = 1'b1;
    end

    if (w_capture) begin
      case (w_dig)
        2'd0: begin segs_d[6:0]   = w_seg_ah; valor_d[3:0]   = w_glyph[3:0]; end
        2'd1: begin segs_d[13:7]  = w_seg_ah; valor_d[7:4]   = w_glyph[3:0]; end
        2'd2: begin segs_d[20:14] = w_seg_ah; valor_d[11:8]  = w_glyph[3:0]; end
        default: begin segs_d[27:21] = w_seg_ah; valor_d[15:12] = w_glyph[3:0]; end
      endcase
      digvalid_d[w_dig] = w_glyph[4];

      case (state_q)
        SYNC: begin
          if (w_dig == 2'd3) begin
            state_d = RUN;
            exp_d   = 2'd2;
          end
        end
        default: begin
          if (w_dig == exp_q) begin
            if (w_dig == 2'd0) begin
              frame_d = 1'b1;
              exp_d   = 2'd3;
            end else begin
              exp_d = exp_q - 2'd1;
            end
          end else begin
            errord_d = 1'b1;
            // An out-of-order digit 3 is itself a valid frame start
            if (w_dig == 2'd3) begin
              state_d = RUN;
              exp_d   = 2'd2;
            end else begin
              state_d = SYNC;
              exp_d   = 2'd3;
            end
          end
        end
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      an_q       <= 4'b1111;
      sg_q       <= 7'h7F;
      cnt_q      <= 4'd0;
      armed_q    <= 1'b0;
      segs_q     <= '0;
      valor_q    <= '0;
      digvalid_q <= '0;
      state_q    <= SYNC;
      exp_q      <= 2'd3;
      frame_q    <= 1'b0;
      errpat_q   <= 1'b0;
      errord_q   <= 1'b0;
    end else begin
      an_q       <= an_d;
      sg_q       <= sg_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      segs_q     <= segs_d;
      valor_q    <= valor_d;
      digvalid_q <= digvalid_d;
      state_q    <= state_d;
      exp_q      <= exp_d;
      frame_q    <= frame_d;
      errpat_q   <= errpat_d;
      errord_q   <= errord_d;
    end
  end

  assign o_Segs      = segs_q;
  assign o_Valor     = valor_q;
  assign o_DigValid  = digvalid_q;
  assign o_Frame     = frame_q;
  assign o_ErrPatron = errpat_q;
  assign o_ErrOrden  = errord_q;

endmodule
`default_nettype wire

// File: tb/tb_deco_anillo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_deco_anillo_rx
// Purpose  : Directed self-checking bench for deco_anillo_rx. One instance uses
//            the default one-cycle dwell, a second uses a three-cycle dwell.
// Revision : 1.0 - initial release
// ============================================================================
module tb_deco_anillo_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  sg  = 7'h7F;
  logic        clr = 1'b0;

  logic [27:0] segs1, segs3;
  logic [15:0] valor1, valor3;
  logic [3:0]  dv1, dv3;
  logic        frame1, frame3;
  logic        errp1, errp3;
  logic        erro1, erro3;

  int errors = 0;
  int checks = 0;
  int tick_no = 0;
  int nframes = 0;
  int fr_ticks[$];

  localparam logic [27:0] C_SEGS_0123 = {7'h3F, 7'h06, 7'h5B, 7'h4F};

  deco_anillo_rx #(.STABLE_CYCLES(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Anodos(an), .i_Segmentos(sg), .i_ClrErr(clr),
    .o_Segs(segs1), .o_Valor(valor1), .o_DigValid(dv1), .o_Frame(frame1),
    .o_ErrPatron(errp1), .o_ErrOrden(erro1)
  );

  deco_anillo_rx #(.STABLE_CYCLES(3)) dut3 (
    .i_Clk(clk), .i_Reset(rst), .i_Anodos(an), .i_Segmentos(sg), .i_ClrErr(clr),
    .o_Segs(segs3), .o_Valor(valor3), .o_DigValid(dv3), .o_Frame(frame3),
    .o_ErrPatron(errp3), .o_ErrOrden(erro3)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Drive one clock of scan bus (segments given active-high), sample 1 ns later
  task automatic tick(input logic [3:0] a, input logic [6:0] s_ah, input logic c);
    an  = a;
    sg  = ~s_ah;
    clr = c;
    @(posedge clk);
    #1;
    tick_no++;
    if (frame1) begin
      nframes++;
      fr_ticks.push_back(tick_no);
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) tick(4'hF, 7'h00, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    rst = 1'b1;
    tick(4'hF, 7'h00, 1'b0);
    rst = 1'b0;
    chk("rst_segs", 32'(segs1), 32'h0);
    chk("rst_valor", 32'(valor1), 32'h0);
    chk("rst_dv", 32'(dv1), 32'h0);
    chk("rst_frame", 32'(frame1), 32'h0);
    chk("rst_errp", 32'(errp1), 32'h0);
    chk("rst_erro", 32'(erro1), 32'h0);

    // ---- first frame, one clock per digit ----
    tick(4'b0111, 7'h3F, 1'b0);
    tick(4'b1011, 7'h06, 1'b0);
    chk("d3_capture", 32'(valor1[15:12]), 32'h0);
    chk("d3_valid", 32'(dv1), 32'h8);
    tick(4'b1101, 7'h5B, 1'b0);
    tick(4'b1110, 7'h4F, 1'b0);
    chk("frame_early", 32'(frame1), 32'h0);
    tick(4'hF, 7'h00, 1'b0);
    chk("f1_valor", 32'(valor1), 32'h0123);
    chk("f1_dv", 32'(dv1), 32'hF);
    chk("f1_segs", 32'(segs1), 32'(C_SEGS_0123));
    chk("f1_frame", 32'(frame1), 32'h1);
    chk("f1_errs", 32'({errp1, erro1}), 32'h0);
    tick(4'hF, 7'h00, 1'b0);
    chk("f1_frame_one_cycle", 32'(frame1), 32'h0);

    // ---- three continuous frames ----
    nframes = 0;
    fr_ticks.delete();
    for (int f = 0; f < 3; f++) begin
      tick(4'b0111, 7'h3F, 1'b0);
      tick(4'b1011, 7'h06, 1'b0);
      tick(4'b1101, 7'h5B, 1'b0);
      tick(4'b1110, 7'h4F, 1'b0);
    end
    blank(2);
    chk("cont_frames", 32'(nframes), 32'd3);
    if (fr_ticks.size() == 3) begin
      chk("cont_spacing_a", 32'(fr_ticks[1] - fr_ticks[0]), 32'd4);
      chk("cont_spacing_b", 32'(fr_ticks[2] - fr_ticks[1]), 32'd4);
    end
    chk("cont_errs", 32'({errp1, erro1}), 32'h0);

    // ---- skipped digit 1 ----
    nframes = 0;
    tick(4'b0111, 7'h3F, 1'b0);
    tick(4'b1011, 7'h06, 1'b0);
    tick(4'b1110, 7'h4F, 1'b0);
    chk("skip_no_err_yet", 32'(erro1), 32'h0);
    tick(4'hF, 7'h00, 1'b0);
    chk("skip_erro", 32'(erro1), 32'h1);
    chk("skip_no_frame", 32'(nframes), 32'd0);
    tick(4'hF, 7'h00, 1'b1);
    chk("skip_clr", 32'(erro1), 32'h0);
    // FSM must be in SYNC: a lone digit-2 capture is not an error
    tick(4'b1011, 7'h06, 1'b0);
    tick(4'hF, 7'h00, 1'b0);
    chk("sync_no_err", 32'(erro1), 32'h0);
    tick(4'b0111, 7'h3F, 1'b0);
    tick(4'b1011, 7'h06, 1'b0);
    tick(4'b1101, 7'h5B, 1'b0);
    tick(4'b1110, 7'h4F, 1'b0);
    tick(4'hF, 7'h00, 1'b0);
    chk("resume_frame", 32'(frame1), 32'h1);
    chk("resume_erro", 32'(erro1), 32'h0);

    // ---- illegal anode pattern ----
    tick(4'b0011, 7'h3F, 1'b0);
    chk("pat_not_yet", 32'(errp1), 32'h0);
    tick(4'hF, 7'h00, 1'b0);
    chk("pat_errp", 32'(errp1), 32'h1);
    chk("pat_valor_kept", 32'(valor1), 32'h0123);
    chk("pat_segs_kept", 32'(segs1), 32'(C_SEGS_0123));
    tick(4'hF, 7'h00, 1'b1);
    chk("pat_clr", 32'(errp1), 32'h0);
    tick(4'b0011, 7'h3F, 1'b0);
    tick(4'hF, 7'h00, 1'b1);
    chk("pat_set_wins", 32'(errp1), 32'h1);
    tick(4'hF, 7'h00, 1'b1);
    blank(3);
    chk("blank_no_err", 32'(errp1), 32'h0);
    chk("blank_no_capture", 32'(valor1), 32'h0123);

    // ---- hex letters A b d F ----
    tick(4'b0111, 7'h77, 1'b0);
    tick(4'b1011, 7'h7C, 1'b0);
    tick(4'b1101, 7'h5E, 1'b0);
    tick(4'b1110, 7'h71, 1'b0);
    tick(4'hF, 7'h00, 1'b0);
    chk("hex_valor", 32'(valor1), 32'hABDF);
    chk("hex_dv", 32'(dv1), 32'hF);
    chk("hex_frame", 32'(frame1), 32'h1);

    // ---- back-to-back digit 0 dwells, second one an illegal glyph ----
    tick(4'b1110, 7'h4F, 1'b0);
    tick(4'b1110, 7'h49, 1'b0);
    chk("b2b_first_val", 32'(valor1[3:0]), 32'h3);
    chk("b2b_first_dv", 32'(dv1[0]), 32'h1);
    chk("b2b_order_err", 32'(erro1), 32'h1);
    tick(4'hF, 7'h00, 1'b0);
    chk("bad_glyph_segs", 32'(segs1[6:0]), 32'h49);
    chk("bad_glyph_dv", 32'(dv1), 32'hE);
    chk("bad_glyph_val", 32'(valor1), 32'hABD0);

    // ---- reset mid-scan ----
    tick(4'b0111, 7'h3F, 1'b0);
    tick(4'b1011, 7'h06, 1'b0);
    rst = 1'b1;
    tick(4'b1101, 7'h5B, 1'b0);
    rst = 1'b0;
    chk("mid_rst_segs", 32'(segs1), 32'h0);
    chk("mid_rst_valor", 32'(valor1), 32'h0);
    chk("mid_rst_flags", 32'({dv1, frame1, errp1, erro1}), 32'h0);

    // ---- three-cycle dwell instance ----
    tick(4'b1101, 7'h6D, 1'b0);
    tick(4'b1101, 7'h6D, 1'b0);
    blank(4);
    chk("s3_short_valor", 32'(valor3), 32'h0);
    chk("s3_short_dv", 32'(dv3), 32'h0);
    tick(4'b0111, 7'h6D, 1'b0);
    tick(4'b0111, 7'h6D, 1'b0);
    tick(4'b0111, 7'h6D, 1'b0);
    chk("s3_not_yet", 32'(valor3), 32'h0);
    tick(4'b0111, 7'h6D, 1'b0);
    chk("s3_valor", 32'(valor3), 32'h5000);
    chk("s3_dv", 32'(dv3), 32'h8);
    chk("s3_segs", 32'(segs3[27:21]), 32'h6D);
    for (int i = 0; i < 9; i++) tick(4'b0111, 7'h6D, 1'b0);
    // A second digit-3 capture while in RUN would raise the order flag
    chk("s3_once", 32'(erro3), 32'h0);
    chk("s3_hold_valor", 32'(valor3), 32'h5000);
    blank(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
